// File: rtl/systolic_result_collector_pkg.sv
// Shared types and sizing helpers for the systolic result collector.
// Imported by the collector top and its result buffer.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN,
    DONE
  } collector_state_e;

  // Address width never drops below one bit, even for a 1x1 array.
  function automatic int ADDR_W(input int n);
    return (n * n > 1) ? $clog2(n * n) : 1;
  endfunction

  function automatic int CNT_W(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/systolic_result_collector_if.sv
// Bottom-edge result inputs and the valid/ready output stream of the collector.
// The master drives results and ready; the slave (collector) drives the stream.
interface systolic_result_collector_if #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32
);

  logic [DATA_WIDTH-1:0] result [0:N-1];
  logic [N-1:0]          result_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (
    output result, result_valid, out_ready,
    input  out_data, out_valid, out_last
  );

  modport slave (
    input  result, result_valid, out_ready,
    output out_data, out_valid, out_last
  );

endinterface

// File: rtl/systolic_result_collector_buffer.sv
// N*N result buffer: one write port per array column, one registered read port.
// Only the read register is reset; the storage array itself is not.
module result_buffer_sram
  import systolic_pkg::*;
#(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                             clk_i,
  input  logic                             rstn_i,
  input  logic [N-1:0]                     wr_en,
  input  logic [N-1:0][ADDR_W(N)-1:0]      wr_addr,
  input  logic [DATA_WIDTH-1:0]            wr_data [N],
  input  logic                             rd_en,
  input  logic [ADDR_W(N)-1:0]             rd_addr,
  output logic [DATA_WIDTH-1:0]            rd_data
);

  logic [DATA_WIDTH-1:0] mem [N*N];

  // Columns always target distinct addresses, so the write ports never collide.
  always_ff @(posedge clk_i) begin
    for (int j = 0; j < N; j++) begin
      if (wr_en[j]) begin
        mem[wr_addr[j]] <= wr_data[j];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/systolic_result_collector.sv
// Gathers skewed bottom-edge results of an N x N systolic array into a row-major
// matrix, then streams it out one word per cycle over valid/ready.
module systolic_result_collector
  import systolic_pkg::*;
#(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       start_i,
  systolic_result_collector_if.slave bus,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       overflow_o
);

  localparam int AW = ADDR_W(N);
  localparam int CW = CNT_W(N);
  localparam logic [AW-1:0] LAST_ADDR = AW'(N * N - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(N);

  collector_state_e      state_q, state_d;
  logic [N-1:0][CW-1:0]  row_cnt_q, row_cnt_d;
  logic [AW-1:0]         rd_addr_q, rd_addr_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic                  overflow_q, overflow_d;
  logic [N-1:0]          wr_en;
  logic [N-1:0][AW-1:0]  wr_addr;
  logic                  rd_en;
  logic                  all_full;
  logic [DATA_WIDTH-1:0] rd_data;

  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    rd_addr_d   = rd_addr_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    overflow_d  = overflow_q;
    wr_en       = '0;
    rd_en       = 1'b0;
    all_full    = 1'b1;

    for (int j = 0; j < N; j++) begin
      wr_addr[j] = AW'(row_cnt_q[j]) * AW'(N) + AW'(j);
      if (row_cnt_q[j] != FULL_CNT) begin
        all_full = 1'b0;
      end
    end

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d    = COLLECT;
          row_cnt_d  = '0;
          rd_addr_d  = '0;
          overflow_d = 1'b0;
        end
      end

      COLLECT: begin
        if (all_full) begin
          state_d = DRAIN;
        end
        // A full column drops further words and flags the error.
        for (int j = 0; j < N; j++) begin
          if (bus.result_valid[j]) begin
            if (row_cnt_q[j] != FULL_CNT) begin
              wr_en[j]     = 1'b1;
              row_cnt_d[j] = row_cnt_q[j] + CW'(1);
            end else begin
              overflow_d = 1'b1;
            end
          end
        end
      end

      DRAIN: begin
        if (|bus.result_valid) begin
          overflow_d = 1'b1;
        end
        // out_last_q marks that every word has already been loaded.
        if (out_last_q) begin
          if (bus.out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            state_d     = DONE;
          end
        end else if (!out_valid_q || bus.out_ready) begin
          rd_en       = 1'b1;
          out_valid_d = 1'b1;
          out_last_d  = (rd_addr_q == LAST_ADDR);
          rd_addr_d   = rd_addr_q + AW'(1);
        end
      end

      DONE: begin
        if (|bus.result_valid) begin
          overflow_d = 1'b1;
        end
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      row_cnt_q   <= '0;
      rd_addr_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      rd_addr_q   <= rd_addr_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      overflow_q  <= overflow_d;
    end
  end

  result_buffer_sram #(
    .N          (N),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buffer (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (bus.result),
    .rd_en   (rd_en),
    .rd_addr (rd_addr_q),
    .rd_data (rd_data)
  );

  assign bus.out_data  = rd_data;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign busy_o        = (state_q != IDLE);
  assign done_o        = (state_q == DONE);
  assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_systolic_result_collector.sv
// Randomized self-checking bench: a row-major matrix model built from the
// column pulses is compared against the streamed output of the collector.
module tb_systolic_result_collector;

  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int WORDS = N * N;

  logic clk_i = 1'b0;
  logic rstn_i;
  logic start_i;
  logic busy_o;
  logic done_o;
  logic overflow_o;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] mat [N][N];
  int            delay_cfg  [N];
  int            target_cfg [N];
  bit            gap_en;
  bit            use_pattern;
  int            start_glitch_cyc;
  bit            exp_ovf;

  systolic_result_collector_if #(.N(N), .DATA_WIDTH(DW)) bus ();

  systolic_result_collector #(.N(N), .DATA_WIDTH(DW)) dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .start_i    (start_i),
    .bus        (bus),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .overflow_o (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic set_cfg(input int delay_mode, input bit gaps, input bit pattern);
    for (int j = 0; j < N; j++) begin
      target_cfg[j] = N;
      case (delay_mode)
        0:       delay_cfg[j] = 0;
        1:       delay_cfg[j] = j;
        default: delay_cfg[j] = $urandom_range(3);
      endcase
    end
    gap_en      = gaps;
    use_pattern = pattern;
  endtask

  task automatic start_matrix(input string tag);
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    n_checks++;
    if ({busy_o, overflow_o, bus.out_valid} !== 3'b100)
      $display("[TB] FAIL %s_start busy/ovf/valid got=%b expected=100", tag, {busy_o, overflow_o, bus.out_valid});
    else n_pass++;
  endtask

  task automatic feed(input string tag);
    int sent [N];
    int cyc;
    bit more;
    bit saw_valid;
    for (int j = 0; j < N; j++) sent[j] = 0;
    exp_ovf   = 1'b0;
    saw_valid = 1'b0;
    cyc       = 0;
    more      = 1'b1;
    while (more && cyc < 300) begin
      more = 1'b0;
      for (int j = 0; j < N; j++) begin
        logic [DW-1:0] v;
        bus.result_valid[j] = 1'b0;
        if (sent[j] < target_cfg[j] && cyc >= delay_cfg[j] &&
            (!gap_en || $urandom_range(3) != 0)) begin
          if (use_pattern) v = DW'(16 * sent[j] + j);
          else             v = $urandom;
          bus.result[j]       = v;
          bus.result_valid[j] = 1'b1;
          if (sent[j] < N) mat[sent[j]][j] = v;
          else             exp_ovf = 1'b1;
          sent[j]++;
        end
        if (sent[j] < target_cfg[j]) more = 1'b1;
      end
      start_i = (cyc == start_glitch_cyc);
      @(posedge clk_i); #1;
      cyc++;
      if (bus.out_valid) saw_valid = 1'b1;
    end
    bus.result_valid = '0;
    start_i          = 1'b0;
    n_checks++;
    if (saw_valid !== 1'b0)
      $display("[TB] FAIL %s_early_valid got=%b expected=0", tag, saw_valid);
    else n_pass++;
  endtask

  // mode 1: ready high, 2: ready 1,0,0 repeating, 3: random ready.
  task automatic run_drain(input int mode, input int stop_after, input int start_cyc, input string tag);
    int idx      = 0;
    int cyc      = 0;
    int dones    = 0;
    int first_hs = -1;
    int last_hs  = -1;
    bit stall    = 1'b0;
    bit r        = 1'b1;
    bit fin      = 1'b0;
    logic [DW-1:0] pd = '0;
    logic          pl = 1'b0;
    while (!fin && cyc < 500) begin
      if (stall) begin
        n_checks++;
        if ({bus.out_valid, bus.out_last, bus.out_data} !== {1'b1, pl, pd})
          $display("[TB] FAIL %s_hold got=%b/%b/%h expected=1/%b/%h", tag, bus.out_valid, bus.out_last, bus.out_data, pl, pd);
        else n_pass++;
      end
      case (mode)
        1:       r = 1'b1;
        2:       r = (cyc % 3 == 0);
        default: r = 1'($urandom_range(1));
      endcase
      bus.out_ready = r;
      start_i       = (cyc == start_cyc);
      if (bus.out_valid && r) begin
        n_checks++;
        if (idx >= WORDS)
          $display("[TB] FAIL %s_extra_word got=%h expected=none", tag, bus.out_data);
        else if (bus.out_data !== mat[idx / N][idx % N])
          $display("[TB] FAIL %s_word%0d got=%h expected=%h", tag, idx, bus.out_data, mat[idx / N][idx % N]);
        else n_pass++;
        n_checks++;
        if (bus.out_last !== (idx == WORDS - 1))
          $display("[TB] FAIL %s_last%0d got=%b expected=%b", tag, idx, bus.out_last, (idx == WORDS - 1));
        else n_pass++;
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        idx++;
      end
      stall = bus.out_valid && !r;
      pd    = bus.out_data;
      pl    = bus.out_last;
      @(posedge clk_i); #1;
      cyc++;
      if (done_o) dones++;
      if (stop_after > 0 && idx == stop_after) fin = 1'b1;
      if (dones > 0 && !busy_o) fin = 1'b1;
    end
    start_i       = 1'b0;
    bus.out_ready = 1'b1;
    n_checks++;
    if (fin !== 1'b1)
      $display("[TB] FAIL %s_timeout got=%0d words expected=%0d", tag, idx, (stop_after > 0) ? stop_after : WORDS);
    else n_pass++;
    if (stop_after == 0) begin
      n_checks++;
      if (idx !== WORDS) $display("[TB] FAIL %s_count got=%0d expected=%0d", tag, idx, WORDS);
      else n_pass++;
      n_checks++;
      if (dones !== 1) $display("[TB] FAIL %s_done_pulses got=%0d expected=1", tag, dones);
      else n_pass++;
      n_checks++;
      if ({busy_o, done_o, bus.out_valid, bus.out_last} !== 4'b0000)
        $display("[TB] FAIL %s_idle_after got=%b expected=0000", tag, {busy_o, done_o, bus.out_valid, bus.out_last});
      else n_pass++;
      n_checks++;
      if (overflow_o !== exp_ovf) $display("[TB] FAIL %s_overflow got=%b expected=%b", tag, overflow_o, exp_ovf);
      else n_pass++;
      if (mode == 1) begin
        n_checks++;
        if (last_hs - first_hs !== WORDS - 1)
          $display("[TB] FAIL %s_throughput got=%0d expected=%0d", tag, last_hs - first_hs, WORDS - 1);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({busy_o, done_o, overflow_o, bus.out_valid, bus.out_last} !== 5'b0)
      $display("[TB] FAIL reset_flags got=%b expected=00000", {busy_o, done_o, overflow_o, bus.out_valid, bus.out_last});
    else n_pass++;
    n_checks++;
    if (bus.out_data !== '0) $display("[TB] FAIL reset_data got=%h expected=0", bus.out_data);
    else n_pass++;
    #11 rstn_i = 1'b1;
    @(posedge clk_i); #1;
    // Results arriving while idle must be ignored.
    bus.result_valid = '1;
    @(posedge clk_i); #1;
    bus.result_valid = '0;
    n_checks++;
    if ({busy_o, overflow_o} !== 2'b00) $display("[TB] FAIL idle_ignore got=%b expected=00", {busy_o, overflow_o});
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    set_cfg(0, 1'b0, 1'b1);
    start_matrix("simul");
    feed("simul");
    run_drain(1, 0, -1, "simul");
  endtask

  task automatic test_skew();
    set_cfg(1, 1'b0, 1'b1);
    start_matrix("skew");
    feed("skew");
    run_drain(1, 0, -1, "skew");
  endtask

  task automatic test_backpressure();
    set_cfg(2, 1'b0, 1'b0);
    start_matrix("bp");
    feed("bp");
    run_drain(2, 0, -1, "bp");
  endtask

  task automatic test_overflow();
    set_cfg(1, 1'b0, 1'b0);
    for (int j = 0; j < N; j++) delay_cfg[j] = (j == 2) ? 0 : 1;
    target_cfg[2] = N + 1;
    start_matrix("ovf");
    feed("ovf");
    n_checks++;
    if (overflow_o !== 1'b1) $display("[TB] FAIL ovf_flag got=%b expected=1", overflow_o);
    else n_pass++;
    run_drain(1, 0, -1, "ovf");
    set_cfg(2, 1'b0, 1'b0);
    start_matrix("ovf_clear");
    feed("ovf_clear");
    run_drain(1, 0, -1, "ovf_clear");
  endtask

  task automatic test_start_ignored();
    set_cfg(2, 1'b0, 1'b0);
    start_glitch_cyc = 2;
    start_matrix("startign");
    feed("startign");
    start_glitch_cyc = -1;
    run_drain(1, 0, 5, "startign");
  endtask

  task automatic test_reset_mid_drain();
    set_cfg(2, 1'b0, 1'b0);
    start_matrix("rstmid");
    feed("rstmid");
    run_drain(1, 7, -1, "rstmid");
    n_checks++;
    if ({busy_o, bus.out_valid} !== 2'b11) $display("[TB] FAIL rstmid_pre got=%b expected=11", {busy_o, bus.out_valid});
    else n_pass++;
    #2 rstn_i = 1'b0;
    #1;
    n_checks++;
    if ({busy_o, bus.out_valid, bus.out_last, done_o} !== 4'b0000)
      $display("[TB] FAIL rstmid_async got=%b expected=0000", {busy_o, bus.out_valid, bus.out_last, done_o});
    else n_pass++;
    n_checks++;
    if (bus.out_data !== '0) $display("[TB] FAIL rstmid_data got=%h expected=0", bus.out_data);
    else n_pass++;
    #2 rstn_i = 1'b1;
    @(posedge clk_i); #1;
    set_cfg(2, 1'b1, 1'b0);
    start_matrix("rstmid_new");
    feed("rstmid_new");
    run_drain(3, 0, -1, "rstmid_new");
  endtask

  task automatic test_random();
    for (int k = 0; k < 3; k++) begin
      set_cfg(2, 1'b1, 1'b0);
      start_matrix("rand");
      feed("rand");
      run_drain(3, 0, -1, "rand");
    end
  endtask

  initial begin
    rstn_i           = 1'b0;
    start_i          = 1'b0;
    start_glitch_cyc = -1;
    bus.out_ready    = 1'b1;
    bus.result_valid = '0;
    for (int j = 0; j < N; j++) bus.result[j] = '0;
    test_reset();
    test_simultaneous();
    test_skew();
    test_backpressure();
    test_overflow();
    test_start_ignored();
    test_reset_mid_drain();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
